serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/fa_bit.sv | 13 +
 rtl/serial_adder.sv | 142 ++++++++++++++
 tb/tb_serial_adder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/fa_bit.sv
// Single-bit full adder cell; the only arithmetic element of the serial adder.
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one sum bit per cycle, LSB first, with a valid/ready handshake on both sides.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_r;
   state_t           state_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] sum_r;
   logic             carry_r;
   logic [CNT_W-1:0] cnt_r;
   logic             accept_s;
   logic             last_bit_s;
   logic             fa_sum_s;
   logic             fa_carry_s;

   assign accept_s   = (state_r == IDLE) && in_valid;
   assign last_bit_s = (cnt_r == CNT_LAST);

   fa_bit u_fa (
      .a  (a_sh_r[0]),
      .b  (b_sh_r[0]),
      .ci (carry_r),
      .s  (fa_sum_s),
      .co (fa_carry_s)
   );

   // Next-state logic: accept in IDLE, WIDTH shift cycles, wait for consumer in HOLD.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (last_bit_s) begin
               state_s = HOLD;
            end else begin
               state_s = SHIFT;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State register; handshake flags are decoded from the next state so they leave as flops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         in_ready_r  <= (state_s == IDLE);
         out_valid_r <= (state_s == HOLD);
      end
   end

   // Operand shifters, sum shifter, carry flop and bit counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh_r  <= {WIDTH{1'b0}};
         b_sh_r  <= {WIDTH{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         a_sh_r  <= a;
         b_sh_r  <= b;
         carry_r <= cin;
         cnt_r   <= {CNT_W{1'b0}};
      end else if (state_r == SHIFT) begin
         // Sum enters at the MSB so bit 0 reaches position 0 after WIDTH shifts.
         a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
         b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
         sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
         carry_r <= fa_carry_s;
         if (!last_bit_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic ovf_r;

   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if ((state_r == SHIFT) && last_bit_s) begin
         ovf_r <= carry_r ^ fa_carry_s;
      end
   end

   assign ovf = ovf_r;
`endif

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign sum       = sum_r;
   assign cout      = carry_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases, backpressure, mid-transaction
// reset and randomized transactions against an arithmetic reference model.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         in_ready;
   logic [W-1:0] a         = '0;
   logic [W-1:0] b         = '0;
   logic         cin       = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int total = 0;
   int bad   = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

`ifndef SERIAL_ADDER_OVF_EN
   assign ovf = 1'b0;
`endif

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, unsigned for sum/cout and signed for overflow.
   task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        output logic [W-1:0] s, output logic co, output logic o);
      int unsigned u;
      int          sg;
      u  = int'(x) + int'(y) + int'(c);
      s  = u[W-1:0];
      co = u[W];
      sg = int'($signed(x)) + int'($signed(y)) + int'(c);
      o  = (sg > (2 ** (W - 1)) - 1) || (sg < -(2 ** (W - 1)));
   endtask

   // Issue one operand set and wait (bounded) until the result is presented; stays in HOLD.
   task automatic run_txn(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          output logic [W-1:0] s, output logic co, output logic o,
                          output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      a = x; b = y; cin = c; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 4 * W) begin
         a         = W'($urandom);
         b         = W'($urandom);
         cin       = 1'($urandom);
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      s  = sum;
      co = cout;
      o  = ovf;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b1;
      a = 8'hFF; b = 8'hFF; cin = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
      end
      total++;
      if (sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
         bad++;
         $display("FAIL reset_data got sum=%h cout=%b ovf=%b exp 00 0 0", sum, cout, ovf);
      end
      in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [W-1:0] va [5] = '{8'h0F, 8'hFF, 8'hFF, 8'h7F, 8'h80};
      logic [W-1:0] vb [5] = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h80};
      logic         vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [W-1:0] es [5] = '{8'h10, 8'h00, 8'h00, 8'h80, 8'h00};
      logic         ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic         eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [W-1:0] s;
      logic         co;
      logic         o;
      int           lat;
      for (int i = 0; i < 5; i++) begin
         run_txn(va[i], vb[i], vc[i], s, co, o, lat);
         total++;
         if (lat !== W) begin
            bad++;
            $display("FAIL dir_latency[%0d] got %0d exp %0d", i, lat, W);
         end
         total++;
         if (s !== es[i] || co !== ec[i]) begin
            bad++;
            $display("FAIL dir_sum[%0d] got sum=%h cout=%b exp %h %b", i, s, co, es[i], ec[i]);
         end
`ifdef SERIAL_ADDER_OVF_EN
         total++;
         if (o !== eo[i]) begin
            bad++;
            $display("FAIL dir_ovf[%0d] got %b exp %b", i, o, eo[i]);
         end
`endif
         handshake();
         total++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL dir_release[%0d] got in_ready=%b out_valid=%b exp 1 0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] s, es;
      logic         co, eco, o, eo;
      int           lat;
      model(8'h5A, 8'h33, 1'b1, es, eco, eo);
      run_txn(8'h5A, 8'h33, 1'b1, s, co, o, lat);
      total++;
      if (s !== es || co !== eco) begin
         bad++;
         $display("FAIL bp_result got sum=%h cout=%b exp %h %b", s, co, es, eco);
      end
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         @(posedge clk); #1;
         total++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== es || cout !== eco) begin
            bad++;
            $display("FAIL bp_hold[%0d] got ov=%b ir=%b sum=%h cout=%b exp 1 0 %h %b",
                     k, out_valid, in_ready, sum, cout, es, eco);
         end
      end
      in_valid = 1'b0;
      handshake();
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_midreset();
      logic [W-1:0] s;
      logic         co, o;
      int           lat;
      int           pulses;
      a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
         bad++;
         $display("FAIL midreset_state got ir=%b ov=%b sum=%h cout=%b exp 1 0 00 0",
                  in_ready, out_valid, sum, cout);
      end
      rst_n = 1'b1;
      pulses = 0;
      repeat (W + 3) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      total++;
      if (pulses !== 0) begin
         bad++;
         $display("FAIL midreset_no_pulse got %0d exp 0", pulses);
      end
      run_txn(8'h12, 8'h34, 1'b0, s, co, o, lat);
      total++;
      if (s !== 8'h46 || co !== 1'b0 || lat !== W) begin
         bad++;
         $display("FAIL midreset_next got sum=%h cout=%b lat=%0d exp 46 0 %0d", s, co, lat, W);
      end
      handshake();
   endtask

   task automatic test_random();
      logic [W-1:0] x, y, s, es;
      logic         c, co, eco, o, eo;
      int           lat;
      int           hold;
      int           bad_before;
      bad_before = bad;
      for (int n = 0; n < 1000; n++) begin
         x = W'($urandom); y = W'($urandom); c = 1'($urandom);
         hold = int'($urandom_range(0, 3));
         model(x, y, c, es, eco, eo);
         run_txn(x, y, c, s, co, o, lat);
         total++;
         if (s !== es || co !== eco || lat !== W) begin
            bad++;
            if (bad - bad_before < 10)
               $display("FAIL rand[%0d] %h+%h+%b got sum=%h cout=%b lat=%0d exp %h %b %0d",
                        n, x, y, c, s, co, lat, es, eco, W);
         end
`ifdef SERIAL_ADDER_OVF_EN
         total++;
         if (o !== eo) begin
            bad++;
            if (bad - bad_before < 10)
               $display("FAIL rand_ovf[%0d] %h+%h+%b got %b exp %b", n, x, y, c, o, eo);
         end
`endif
         repeat (hold) begin
            @(posedge clk); #1;
         end
         handshake();
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            if (bad - bad_before < 10)
               $display("FAIL rand_b2b_ready[%0d] got %b exp 1", n, in_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_midreset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
